// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer: streams a message out of a block-RAM to a UART transmitter
//   clk        - single clock shared with the RAM and the UART TX
//   rst        - synchronous active-high reset
//   start      - begin streaming; only looked at while idle
//   o_raddr    - RAM read address (always the cursor)
//   i_rdata    - RAM read data, valid one cycle after o_raddr
//   o_tx_data  - byte offered to the UART TX
//   o_tx_valid - o_tx_data is valid
//   i_tx_ready - UART TX accepts the byte when valid & ready
//   o_busy     - high whenever not idle
//   o_done     - one-cycle pulse after the final byte (non-repeating only)
//   o_sum      - 16-bit wrapping sum of bytes accepted since the last start
module uart_msg_streamer #(
    parameter int ADDR_W      = 9,
    parameter int MESSAGE_LEN = 512,
    parameter int REPEAT      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] o_raddr,
    input  logic [7:0]        i_rdata,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_sum
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, DONE} state_t;
    // Compared at ADDR_W width so a full-depth message ends on the all-ones address.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MESSAGE_LEN - 1);
    state_t state, state_nx;
    logic [ADDR_W-1:0] cursor;
    logic last;
    logic hs;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = LATCH;
            LATCH:   state_nx = SEND;
            SEND:    state_nx = !i_tx_ready ? SEND : (!last || REPEAT != 0) ? FETCH : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // Valid is a pure decode of the registered state, so it is glitch-free
    // and held for the whole of SEND until the handshake.
    always_comb begin
        o_raddr    = cursor;
        o_busy     = state != IDLE;
        o_done     = state == DONE;
        o_tx_valid = state == SEND;
        last       = cursor == LAST;
        hs         = state == SEND && i_tx_ready;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor    <= '0;
            o_tx_data <= '0;
            o_sum     <= '0;
        end else if (state == IDLE && start) begin
            cursor <= '0;
            o_sum  <= '0;
        end else if (state == LATCH) begin
            o_tx_data <= i_rdata;
        end else if (hs) begin
            o_sum  <= o_sum + 16'(o_tx_data);
            cursor <= !last ? cursor + ADDR_W'(1) : (REPEAT != 0) ? '0 : cursor;
        end
    end
endmodule

// File: tb/tb_uart_msg_streamer.sv
// tb_uart_msg_streamer: self-checking bench for uart_msg_streamer
module tb_uart_msg_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst;
    logic        start   [4];
    logic        ready   [4];
    logic [8:0]  raddr   [4];
    logic [7:0]  tx_data [4];
    logic        valid   [4];
    logic        busy    [4];
    logic        done    [4];
    logic [15:0] sum     [4];
    logic [7:0]  mem     [4][512];
    int compared = 0;
    int mismatched = 0;
    int hs_cnt[4];
    int done_cnt[4];
    int max_addr[4];
    logic [15:0] model_sum[4];
    logic stall_prev[4];
    logic [7:0] prev_data[4];

    // Instance 0: 4-byte message, 1: full 512 bytes, 2: 2-byte repeating, 3: single byte
    function automatic int len_of(input int g);
        return g == 0 ? 4 : g == 1 ? 512 : g == 2 ? 2 : 1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : u
        logic [7:0] rd;
        always_ff @(posedge clk) rd <= mem[g][raddr[g]];
        uart_msg_streamer #(.ADDR_W(9), .MESSAGE_LEN(len_of(g)), .REPEAT(g == 2 ? 1 : 0)) dut (
            .clk(clk), .rst(rst), .start(start[g]), .o_raddr(raddr[g]), .i_rdata(rd),
            .o_tx_data(tx_data[g]), .o_tx_valid(valid[g]), .i_tx_ready(ready[g]),
            .o_busy(busy[g]), .o_done(done[g]), .o_sum(sum[g]));
    end

    typedef struct {
        int          g;
        logic [31:0] bytes;
        int          stall_at;
        int          stall_len;
        logic [15:0] exp_sum;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the k-th accepted byte of a stream is mem[k mod LEN]; the sum is their wrapping total.
    task automatic monitor();
        for (int g = 0; g < 4; g++) begin
            if (stall_prev[g]) begin
                check($sformatf("hold_valid%0d", g), 32'(valid[g]), 32'd1);
                check($sformatf("hold_data%0d", g), 32'(tx_data[g]), 32'(prev_data[g]));
            end
            if (valid[g] && ready[g]) begin
                check($sformatf("byte%0d_%0d", g, hs_cnt[g]), 32'(tx_data[g]),
                      32'(mem[g][hs_cnt[g] % len_of(g)]));
                model_sum[g] += 16'(mem[g][hs_cnt[g] % len_of(g)]);
                hs_cnt[g]++;
            end
            stall_prev[g] = valid[g] && !ready[g] && !rst;
            prev_data[g] = tx_data[g];
            if (done[g]) done_cnt[g]++;
            if (int'(raddr[g]) > max_addr[g]) max_addr[g] = int'(raddr[g]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic clear(input int g);
        hs_cnt[g] = 0;
        done_cnt[g] = 0;
        model_sum[g] = 16'd0;
        max_addr[g] = 0;
    endtask

    task automatic do_start(input int g, output int lat);
        clear(g);
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
        lat = 1;
        while (!valid[g] && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, n, stalled, g;
        logic [15:0] ref_sum;
        vt[0] = '{0, 32'h48656C6C, -1, 0, 16'h0185};
        vt[1] = '{0, 32'h48656C6C, 1, 5, 16'h0185};
        vt[2] = '{0, 32'h00000000, -1, 0, 16'h0000};
        vt[3] = '{0, 32'hFFFFFFFF, 2, 3, 16'h03FC};
        vt[4] = '{3, 32'hA5112233, -1, 0, 16'h00A5};
        vt[5] = '{0, 32'h01020304, 3, 2, 16'h000A};
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            ready[i] = 1'b0;
            stall_prev[i] = 1'b0;
            clear(i);
            for (int a = 0; a < 512; a++) mem[i][a] = 8'h00;
        end
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rst_valid", 32'(valid[i]), 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
            check("rst_sum", 32'(sum[i]), 32'd0);
            check("rst_raddr", 32'(raddr[i]), 32'd0);
            check("rst_data", 32'(tx_data[i]), 32'd0);
        end
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            g = vt[v].g;
            for (int i = 0; i < 4; i++) mem[g][i] = vt[v].bytes[31-8*i -: 8];
            ready[g] = 1'b1;
            do_start(g, lat);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'd3);
            stalled = 0;
            n = 0;
            while (done_cnt[g] == 0 && n < 200) begin
                ready[g] = !(valid[g] && hs_cnt[g] == vt[v].stall_at && stalled < vt[v].stall_len);
                if (!ready[g]) stalled++;
                tick();
                n++;
            end
            check($sformatf("v%0d_count", v), 32'(hs_cnt[g]), 32'(len_of(g)));
            check($sformatf("v%0d_sum", v), 32'(sum[g]), 32'(vt[v].exp_sum));
            tick();
            check($sformatf("v%0d_done", v), 32'(done_cnt[g]), 32'd1);
            check($sformatf("v%0d_busy", v), 32'(busy[g]), 32'd0);
            ready[g] = 1'b0;
        end

        for (int a = 0; a < 512; a++) mem[1][a] = 8'hFF;
        ready[1] = 1'b1;
        do_start(1, lat);
        check("full_latency", 32'(lat), 32'd3);
        n = 0;
        while (done_cnt[1] == 0 && n < 2000) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("full_count", 32'(hs_cnt[1]), 32'd512);
        check("full_sum", 32'(sum[1]), 32'h0000FE00);
        check("full_maxaddr", 32'(max_addr[1]), 32'h1FF);
        check("full_done", 32'(done_cnt[1]), 32'd1);
        ready[1] = 1'b0;

        for (int it = 0; it < 17; it++) begin
            g = it < 10 ? 0 : it < 15 ? 3 : 1;
            ref_sum = 16'd0;
            for (int a = 0; a < len_of(g); a++) begin
                mem[g][a] = 8'($urandom_range(0, 255));
                ref_sum += 16'(mem[g][a]);
            end
            ready[g] = 1'b0;
            do_start(g, lat);
            check("rnd_latency", 32'(lat), 32'd3);
            n = 0;
            while (done_cnt[g] == 0 && n < 4000) begin
                ready[g] = $urandom_range(0, 3) != 0;
                start[g] = busy[g] ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
                n++;
            end
            start[g] = 1'b0;
            ready[g] = $urandom_range(0, 1) != 0;
            tick();
            tick();
            check($sformatf("rnd%0d_count", it), 32'(hs_cnt[g]), 32'(len_of(g)));
            check($sformatf("rnd%0d_sum", it), 32'(sum[g]), 32'(ref_sum));
            check($sformatf("rnd%0d_done", it), 32'(done_cnt[g]), 32'd1);
            check($sformatf("rnd%0d_busy", it), 32'(busy[g]), 32'd0);
            ready[g] = 1'b0;
        end

        mem[2][0] = 8'h01;
        mem[2][1] = 8'h02;
        ready[2] = 1'b1;
        do_start(2, lat);
        check("rep_latency", 32'(lat), 32'd3);
        n = 0;
        while (hs_cnt[2] < 6 && n < 100) begin
            tick();
            check("rep_busy", 32'(busy[2]), 32'd1);
            n++;
        end
        check("rep_sum6", 32'(sum[2]), 32'h0009);
        for (int i = 0; i < 60; i++) begin
            ready[2] = $urandom_range(0, 1) != 0;
            start[2] = 1'($urandom_range(0, 1));
            tick();
        end
        start[2] = 1'b0;
        check("rep_sum_model", 32'(sum[2]), 32'(model_sum[2]));
        check("rep_no_done", 32'(done_cnt[2]), 32'd0);
        check("rep_busy_end", 32'(busy[2]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready[2] = 1'b0;
        check("rep_rst_busy", 32'(busy[2]), 32'd0);

        for (int i = 0; i < 4; i++) mem[0][i] = vt[0].bytes[31-8*i -: 8];
        ready[0] = 1'b1;
        do_start(0, lat);
        n = 0;
        while (hs_cnt[0] < 2 && n < 50) begin
            tick();
            n++;
        end
        ready[0] = 1'b0;
        n = 0;
        while (!valid[0] && n < 10) begin
            tick();
            n++;
        end
        check("mid_valid_before", 32'(valid[0]), 32'd1);
        check("mid_sum_before", 32'(sum[0]), 32'h00AD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", 32'(valid[0]), 32'd0);
        check("mid_busy", 32'(busy[0]), 32'd0);
        check("mid_sum", 32'(sum[0]), 32'd0);
        tick();
        tick();
        tick();
        check("mid_no_done", 32'(done_cnt[0]), 32'd0);
        ready[0] = 1'b1;
        do_start(0, lat);
        check("mid_restart_latency", 32'(lat), 32'd3);
        check("mid_restart_addr", 32'(raddr[0]), 32'd0);
        n = 0;
        while (done_cnt[0] == 0 && n < 100) begin
            tick();
            n++;
        end
        check("mid_restart_count", 32'(hs_cnt[0]), 32'd4);
        check("mid_restart_sum", 32'(sum[0]), 32'h0185);
        ready[0] = 1'b0;
        tick();

        mem[3][0] = 8'h5A;
        clear(3);
        ready[3] = 1'b1;
        start[3] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("hold_start_count", 32'(hs_cnt[3]), 32'd2);
        check("hold_start_done", 32'(done_cnt[3]), 32'd2);
        start[3] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("hold_start_idle", 32'(busy[3]), 32'd0);
        check("hold_start_sum", 32'(sum[3]), 32'h005A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
